// File: rtl/memacc_pkg.sv
// Shared types and constants for the memory access sequencer.
//
// Contents:
//   state_e       - sequencer states (IDLE / ACCESS / DONE)
//   owner_e       - access owner (fetch / data)
//   GNT_F_BIT,
//   GNT_D_BIT     - bit positions in the one-hot grant vector
//   CNT_W         - width of the memory latency wait counter
//   MEM_LAT_MAX   - largest latency the counter can hold
//   lat_load()    - converts the latency parameter to a counter load value
package memacc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int unsigned GNT_F_BIT   = 0;
    localparam int unsigned GNT_D_BIT   = 1;

    localparam int unsigned CNT_W       = 4;
    localparam int          MEM_LAT_MAX = (1 << CNT_W) - 1;

    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        return CNT_W'(lat);
    endfunction

endpackage

// File: rtl/memacc_rr_pick.sv
// Two-requester pick between instruction fetch and load/store.
//
// Build option: MEMACC_FETCH_PRIO_EN
//   defined   - fixed priority, fetch wins every tie, last_owner ignored
//   undefined - round-robin: a tie goes to the requester not granted last
//
// Ports:
//   f_req      in   fetch request
//   d_req      in   data request
//   last_owner in   owner of the most recent grant
//   gnt        out  one-hot grant, bit GNT_F_BIT = fetch, bit GNT_D_BIT = data
module memacc_rr_pick
    import memacc_pkg::*;
(
    input  logic       f_req,
    input  logic       d_req,
    input  owner_e     last_owner,
    output logic [1:0] gnt
);

`ifdef MEMACC_FETCH_PRIO_EN
    // Fixed priority does not need the history bit.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        gnt            = 2'b00;
        gnt[GNT_F_BIT] = f_req;
        gnt[GNT_D_BIT] = d_req & ~f_req;
    end
`else
    always_comb begin
        gnt = 2'b00;
        if (f_req && d_req) begin
            if (last_owner == OWN_D) begin
                gnt[GNT_F_BIT] = 1'b1;
            end else begin
                gnt[GNT_D_BIT] = 1'b1;
            end
        end else begin
            gnt[GNT_F_BIT] = f_req;
            gnt[GNT_D_BIT] = d_req;
        end
    end
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer/arbiter for the single-port data memory and the MD register.
// Shares the memory between instruction fetch and load/store, holds the
// address/write data stable for the whole access and pulses md_en once
// when read data is valid.
//
// Build option: MEMACC_FETCH_PRIO_EN (see memacc_rr_pick) selects fixed
// fetch priority instead of round-robin on ties.
//
// Parameters:
//   AW       address width
//   DW       data width
//   MEM_LAT  cycles from mem_en to valid mem_rd (1..15)
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   f_req, f_addr            fetch request (read only)
//   d_req, d_we, d_addr,
//   d_wdata                  load/store request
//   f_gnt, d_gnt             one-cycle grant pulses
//   f_done, d_done           one-cycle completion pulses
//   mem_en                   one-cycle memory strobe
//   mem_we, mem_addr,
//   mem_wdata                registered access attributes, held from grant
//                            until the next grant
//   mem_rd                   memory read data (consumed by the MD register)
//   md_en                    MD register capture enable
//   busy                     sequencer not idle
module mem_access_ctrl
    import memacc_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          f_gnt,
    output logic          d_gnt,
    output logic          f_done,
    output logic          d_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rd,
    output logic          md_en,
    output logic          busy
);

    if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_bad_mem_lat
        $error("mem_access_ctrl: MEM_LAT must be in 1..15");
    end

    localparam logic [CNT_W-1:0] LAT_LOAD = lat_load(MEM_LAT);

    // Read data goes straight from the memory into the MD register; the
    // port is here so the datapath wiring stays visible at this boundary.
    logic unused_mem_rd;
    assign unused_mem_rd = ^mem_rd;

    state_e           state_q, state_d;
    owner_e           last_owner_q, last_owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             f_gnt_q, f_gnt_d;
    logic             d_gnt_q, d_gnt_d;
    logic             f_done_q, f_done_d;
    logic             d_done_q, d_done_d;
    logic             mem_en_q, mem_en_d;
    logic             mem_we_q, mem_we_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
    logic             md_en_q, md_en_d;
    logic             busy_q, busy_d;
    logic [1:0]       pick_gnt;

    memacc_rr_pick u_pick (
        .f_req      (f_req),
        .d_req      (d_req),
        .last_owner (last_owner_q),
        .gnt        (pick_gnt)
    );

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        f_gnt_d      = 1'b0;
        d_gnt_d      = 1'b0;
        f_done_d     = 1'b0;
        d_done_d     = 1'b0;
        mem_en_d     = 1'b0;
        md_en_d      = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_gnt[GNT_F_BIT]) begin
                    state_d      = ST_ACCESS;
                    last_owner_d = OWN_F;
                    cnt_d        = LAT_LOAD;
                    f_gnt_d      = 1'b1;
                    mem_en_d     = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = f_addr;
                    mem_wdata_d  = '0;
                end else if (pick_gnt[GNT_D_BIT]) begin
                    state_d      = ST_ACCESS;
                    last_owner_d = OWN_D;
                    cnt_d        = LAT_LOAD;
                    d_gnt_d      = 1'b1;
                    mem_en_d     = 1'b1;
                    mem_we_d     = d_we;
                    mem_addr_d   = d_addr;
                    mem_wdata_d  = d_wdata;
                end
            end
            ST_ACCESS: begin
                // Counter holds MEM_LAT in the first ACCESS cycle, so DONE
                // lands exactly MEM_LAT cycles after mem_en.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == '0) begin
                    state_d = ST_DONE;
                    if (last_owner_q == OWN_F) begin
                        f_done_d = 1'b1;
                    end else begin
                        d_done_d = 1'b1;
                    end
                    md_en_d = ~mem_we_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_owner_q <= OWN_D;
            cnt_q        <= '0;
            f_gnt_q      <= 1'b0;
            d_gnt_q      <= 1'b0;
            f_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            md_en_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            f_gnt_q      <= f_gnt_d;
            d_gnt_q      <= d_gnt_d;
            f_done_q     <= f_done_d;
            d_done_q     <= d_done_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            md_en_q      <= md_en_d;
            busy_q       <= busy_d;
        end
    end

    assign f_gnt     = f_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign f_done    = f_done_q;
    assign d_done    = d_done_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign md_en     = md_en_q;
    assign busy      = busy_q;

endmodule
